core_run_ctrl: RTL and testbench

//  Run controller sitting directly upstream of the core's top-level req/done port.

---
 rtl/core_run_ctrl.sv | 103 ++++++++++
 tb/tb_core_run_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_run_ctrl.sv
// rtl/core_run_ctrl.sv - run controller: core reset hold, req/done handshake, cycle count, watchdog
module core_run_ctrl #(
    parameter int CW      = 16,
    parameter int RST_CYC = 2,
    parameter int MAX_CYC = 4095
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          core_reset,
    output logic          core_req,
    input  logic          core_done,
    output logic          busy,
    output logic          finished,
    output logic          timeout,
    output logic [CW-1:0] cycles
);

    localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYC - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(MAX_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_RUN,
        S_DONE,
        S_TOUT
    } state_t;

    state_t        state;
    logic [RW-1:0] rst_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            core_reset <= 1'b1;
            core_req   <= 1'b0;
            busy       <= 1'b0;
            finished   <= 1'b0;
            timeout    <= 1'b0;
            cycles     <= '0;
            rst_cnt    <= '0;
        end else begin
            finished <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_RST;
                        busy    <= 1'b1;
                        cycles  <= '0;
                        timeout <= 1'b0;
                        rst_cnt <= '0;
                    end
                end
                S_RST: begin
                    if (rst_cnt == RST_LAST) begin
                        state      <= S_RUN;
                        core_reset <= 1'b0;
                        core_req   <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    // The done cycle is counted too; done takes priority over the watchdog.
                    cycles <= cycles + 1'b1;
                    if (core_done) begin
                        state    <= S_DONE;
                        core_req <= 1'b0;
                        busy     <= 1'b0;
                        finished <= 1'b1;
                    end else if (cycles == CYC_LAST) begin
                        state      <= S_TOUT;
                        core_req   <= 1'b0;
                        core_reset <= 1'b1;
                        busy       <= 1'b0;
                        timeout    <= 1'b1;
                    end
                end
                S_DONE: begin
                    // Core is left out of reset so its memory can be read back.
                    if (!start) begin
                        state      <= S_IDLE;
                        core_reset <= 1'b1;
                    end
                end
                S_TOUT: begin
                    if (!start) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    core_reset <= 1'b1;
                    core_req   <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb/tb_core_run_ctrl.sv - randomized self-checking bench for core_run_ctrl
module tb_core_run_ctrl;

    localparam int CW      = 16;
    localparam int RST_CYC = 2;
    localparam int MAX_CYC = 8;
    localparam int VW      = CW + 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          core_reset;
    logic          core_req;
    logic          core_done;
    logic          busy;
    logic          finished;
    logic          timeout;
    logic [CW-1:0] cycles;

    int n_checks = 0;
    int n_fail   = 0;
    logic last_tout;
    int   last_cycles;

    core_run_ctrl #(.CW(CW), .RST_CYC(RST_CYC), .MAX_CYC(MAX_CYC)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .core_reset (core_reset),
        .core_req   (core_req),
        .core_done  (core_done),
        .busy       (busy),
        .finished   (finished),
        .timeout    (timeout),
        .cycles     (cycles)
    );

    always #5 clk = ~clk;

    // Outputs packed as {core_reset, core_req, busy, finished, timeout, cycles}
    function automatic logic [VW-1:0] pack(input logic r, input logic q, input logic b,
                                           input logic f, input logic t, input int c);
        return {r, q, b, f, t, CW'(c)};
    endfunction

    function automatic logic [VW-1:0] observed();
        return {core_reset, core_req, busy, finished, timeout, cycles};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete run: done_at in 1..MAX_CYC finishes on that RUN cycle, anything else times out.
    task automatic do_run(input int done_at, input int hold, input bit noise, input string name);
        logic [VW-1:0] exp;
        int  limit;
        bit  tout;
        tout  = !(done_at >= 1 && done_at <= MAX_CYC);
        limit = tout ? MAX_CYC : done_at;

        for (int i = 0; i < 2; i++) begin
            start     = 1'b0;
            core_done = noise;
            step();
            exp = pack(1'b1, 1'b0, 1'b0, 1'b0, last_tout, last_cycles);
            n_checks++;
            if (observed() !== exp) begin
                n_fail++;
                $display("FAIL %s idle: got %h expected %h", name, observed(), exp);
            end
        end

        start     = 1'b1;
        core_done = noise;
        step();
        exp = pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        n_checks++;
        if (observed() !== exp) begin
            n_fail++;
            $display("FAIL %s launch: got %h expected %h", name, observed(), exp);
        end

        for (int i = 1; i <= RST_CYC; i++) begin
            start     = noise ? 1'($urandom_range(0, 1)) : 1'b1;
            core_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            exp = (i == RST_CYC) ? pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0)
                                 : pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
            n_checks++;
            if (observed() !== exp) begin
                n_fail++;
                $display("FAIL %s rst_hold%0d: got %h expected %h", name, i, observed(), exp);
            end
        end

        for (int n = 1; n <= limit; n++) begin
            core_done = (n == done_at);
            if (noise) start = 1'($urandom_range(0, 1));
            step();
            if (n < limit)  exp = pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, n);
            else if (tout)  exp = pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, MAX_CYC);
            else            exp = pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, n);
            n_checks++;
            if (observed() !== exp) begin
                n_fail++;
                $display("FAIL %s run%0d: got %h expected %h", name, n, observed(), exp);
            end
        end

        start = 1'b1;
        for (int h = 0; h < hold; h++) begin
            core_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            exp = tout ? pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, MAX_CYC)
                       : pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, limit);
            n_checks++;
            if (observed() !== exp) begin
                n_fail++;
                $display("FAIL %s end_hold%0d: got %h expected %h", name, h, observed(), exp);
            end
        end

        start     = 1'b0;
        core_done = 1'b0;
        step();
        exp = pack(1'b1, 1'b0, 1'b0, 1'b0, tout, limit);
        n_checks++;
        if (observed() !== exp) begin
            n_fail++;
            $display("FAIL %s return_idle: got %h expected %h", name, observed(), exp);
        end
        last_tout   = tout;
        last_cycles = limit;
    endtask

    task automatic test_reset();
        logic [VW-1:0] exp;
        reset = 1'b1;
        start = 1'b1;
        core_done = 1'b1;
        step();
        step();
        exp = pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        n_checks++;
        if (observed() !== exp) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h", observed(), exp);
        end
        reset = 1'b0;
        start = 1'b0;
        core_done = 1'b0;
        last_tout = 1'b0;
        last_cycles = 0;
    endtask

    task automatic test_done_run();
        do_run(5, 3, 1'b0, "done5");
    endtask

    task automatic test_timeout();
        do_run(0, 2, 1'b0, "timeout");
        do_run(3, 1, 1'b0, "after_timeout");
    endtask

    task automatic test_done_at_limit();
        do_run(MAX_CYC, 1, 1'b0, "done_at_limit");
        do_run(1, 1, 1'b0, "done_first");
    endtask

    task automatic test_reset_mid_run();
        logic [VW-1:0] exp;
        start = 1'b1;
        core_done = 1'b0;
        for (int i = 0; i < RST_CYC + 1 + 3; i++) step();
        exp = pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3);
        n_checks++;
        if (observed() !== exp) begin
            n_fail++;
            $display("FAIL midrun_pre: got %h expected %h", observed(), exp);
        end
        reset = 1'b1;
        step();
        exp = pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        n_checks++;
        if (observed() !== exp) begin
            n_fail++;
            $display("FAIL midrun_reset: got %h expected %h", observed(), exp);
        end
        reset = 1'b0;
        start = 1'b0;
        last_tout = 1'b0;
        last_cycles = 0;
    endtask

    task automatic test_ignored_inputs();
        do_run(4, 2, 1'b1, "noise_done");
        do_run(0, 2, 1'b1, "noise_tout");
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 20; r++) begin
            do_run(int'($urandom_range(0, MAX_CYC + 2)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        core_done = 1'b0;
        last_tout = 1'b0;
        last_cycles = 0;
        test_reset();
        test_done_run();
        test_timeout();
        test_done_at_limit();
        test_reset_mid_run();
        test_ignored_inputs();
        test_random_runs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
